// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - decode-to-execute pipeline register with stall, flush, step gate and HALT drain tracking
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DRAIN_CYCLES   = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [20:0]               i_ctrl,
  input  logic                      i_halt,
  input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
  input  logic [DATA_WIDTH-1:0]     i_rs_data,
  input  logic [DATA_WIDTH-1:0]     i_rt_data,
  input  logic [DATA_WIDTH-1:0]     i_imm_ext,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_sa,
  output logic [20:0]               o_ctrl,
  output logic [DATA_WIDTH-1:0]     o_pc_plus4,
  output logic [DATA_WIDTH-1:0]     o_rs_data,
  output logic [DATA_WIDTH-1:0]     o_rt_data,
  output logic [DATA_WIDTH-1:0]     o_imm_ext,
  output logic [REG_ADDR_WIDTH-1:0] o_rs_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rt_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_sa,
  output logic                      o_valid,
  output logic                      o_mem_read,
  output logic                      o_halt_seen,
  output logic                      o_halted
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_CYCLES);

  logic [20:0]               ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]     pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0]     rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0]     rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0]     imm_ext_q, imm_ext_d;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q, rs_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q, rt_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [REG_ADDR_WIDTH-1:0] sa_q, sa_d;
  logic                      valid_q, valid_d;
  logic                      halt_seen_q, halt_seen_d;
  logic [CNT_W-1:0]          drain_cnt_q, drain_cnt_d;

  logic load_bubble;
  logic load_inputs;

  always_comb begin
    load_bubble = 1'b0;
    load_inputs = 1'b0;
    halt_seen_d = halt_seen_q;
    drain_cnt_d = drain_cnt_q;
    if (i_enable) begin
      if (halt_seen_q) begin
        load_bubble = 1'b1;
        if (drain_cnt_q != CNT_MAX) drain_cnt_d = drain_cnt_q + CNT_W'(1);
      end else if (i_flush) begin
        load_bubble = 1'b1;
      end else if (!i_stall) begin
        // A captured HALT enters EX as a bubble so it can never write state
        if (i_halt) begin
          load_bubble = 1'b1;
          halt_seen_d = 1'b1;
        end else begin
          load_inputs = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    pc_plus4_d = pc_plus4_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_ext_d  = imm_ext_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rd_addr_d  = rd_addr_q;
    sa_d       = sa_q;
    valid_d    = valid_q;
    if (load_bubble) begin
      ctrl_d     = '0;
      pc_plus4_d = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_ext_d  = '0;
      rs_addr_d  = '0;
      rt_addr_d  = '0;
      rd_addr_d  = '0;
      sa_d       = '0;
      valid_d    = 1'b0;
    end else if (load_inputs) begin
      ctrl_d     = i_ctrl;
      pc_plus4_d = i_pc_plus4;
      rs_data_d  = i_rs_data;
      rt_data_d  = i_rt_data;
      imm_ext_d  = i_imm_ext;
      rs_addr_d  = i_rs_addr;
      rt_addr_d  = i_rt_addr;
      rd_addr_d  = i_rd_addr;
      sa_d       = i_sa;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q      <= '0;
      pc_plus4_q  <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_ext_q   <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      sa_q        <= '0;
      valid_q     <= 1'b0;
      halt_seen_q <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      pc_plus4_q  <= pc_plus4_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_ext_q   <= imm_ext_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      sa_q        <= sa_d;
      valid_q     <= valid_d;
      halt_seen_q <= halt_seen_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign o_ctrl      = ctrl_q;
  assign o_pc_plus4  = pc_plus4_q;
  assign o_rs_data   = rs_data_q;
  assign o_rt_data   = rt_data_q;
  assign o_imm_ext   = imm_ext_q;
  assign o_rs_addr   = rs_addr_q;
  assign o_rt_addr   = rt_addr_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_sa        = sa_q;
  assign o_valid     = valid_q;
  // Load in EX: register write sourced from memory rather than the ALU
  assign o_mem_read  = valid_q & ctrl_q[5] & ~ctrl_q[3];
  assign o_halt_seen = halt_seen_q;
  assign o_halted    = (drain_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - vector table, freeze sequence and randomized model check for id_ex_register
module tb_id_ex_register;

  localparam int DRAIN = 3;
  localparam logic [20:0] ADDU = 21'h0A4028;
  localparam logic [20:0] LOAD = 21'h000020;

  logic        clk = 1'b0;
  logic        rst, en, stall, flush, halt;
  logic [20:0] ctrl;
  logic [31:0] pc4, rs_d, rt_d, imm;
  logic [4:0]  rs_a, rt_a, rd_a, sa;
  logic [20:0] o_ctrl;
  logic [31:0] o_pc4, o_rs_d, o_rt_d, o_imm;
  logic [4:0]  o_rs_a, o_rt_a, o_rd_a, o_sa;
  logic        o_valid, o_mem_read, o_halt_seen, o_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_stall(stall), .i_flush(flush),
    .i_ctrl(ctrl), .i_halt(halt), .i_pc_plus4(pc4), .i_rs_data(rs_d), .i_rt_data(rt_d),
    .i_imm_ext(imm), .i_rs_addr(rs_a), .i_rt_addr(rt_a), .i_rd_addr(rd_a), .i_sa(sa),
    .o_ctrl(o_ctrl), .o_pc_plus4(o_pc4), .o_rs_data(o_rs_d), .o_rt_data(o_rt_d),
    .o_imm_ext(o_imm), .o_rs_addr(o_rs_a), .o_rt_addr(o_rt_a), .o_rd_addr(o_rd_a), .o_sa(o_sa),
    .o_valid(o_valid), .o_mem_read(o_mem_read), .o_halt_seen(o_halt_seen), .o_halted(o_halted)
  );

  // Reference state: what the EX stage should hold, and edges counted since HALT capture
  logic [20:0] m_ctrl;
  logic [31:0] m_pc4, m_rs, m_rt, m_imm;
  logic [4:0]  m_rsa, m_rta, m_rd, m_sa;
  logic        m_valid, m_seen;
  int          m_drain;

  task automatic model_bubble();
    m_ctrl = '0; m_pc4 = '0; m_rs = '0; m_rt = '0; m_imm = '0;
    m_rsa = '0; m_rta = '0; m_rd = '0; m_sa = '0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_bubble();
      m_seen = 1'b0;
      m_drain = 0;
    end else if (!en) begin
    end else if (m_seen) begin
      model_bubble();
      if (m_drain < DRAIN) m_drain++;
    end else if (flush) begin
      model_bubble();
    end else if (stall) begin
    end else if (halt) begin
      model_bubble();
      m_seen = 1'b1;
    end else begin
      m_ctrl = ctrl; m_pc4 = pc4; m_rs = rs_d; m_rt = rt_d; m_imm = imm;
      m_rsa = rs_a; m_rta = rt_a; m_rd = rd_a; m_sa = sa; m_valid = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("rnd_ctrl", 64'(o_ctrl), 64'(m_ctrl));
    check("rnd_pc4", 64'(o_pc4), 64'(m_pc4));
    check("rnd_rs_data", 64'(o_rs_d), 64'(m_rs));
    check("rnd_rt_data", 64'(o_rt_d), 64'(m_rt));
    check("rnd_imm", 64'(o_imm), 64'(m_imm));
    check("rnd_addrs", 64'({o_rs_a, o_rt_a, o_rd_a, o_sa}), 64'({m_rsa, m_rta, m_rd, m_sa}));
    check("rnd_valid", 64'(o_valid), 64'(m_valid));
    check("rnd_mem_read", 64'(o_mem_read), 64'(m_valid && m_ctrl[5] && !m_ctrl[3]));
    check("rnd_halt_seen", 64'(o_halt_seen), 64'(m_seen));
    check("rnd_halted", 64'(o_halted), 64'(m_drain == DRAIN));
  endtask

  typedef struct {
    logic        rst, en, stall, flush, halt;
    logic [20:0] ctrl;
    logic [31:0] rs, rt;
    logic [4:0]  rta, rd;
    logic [20:0] e_ctrl;
    logic [31:0] e_rs, e_rt;
    logic [4:0]  e_rta, e_rd;
    logic        e_valid, e_mr, e_seen, e_halted;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, e, s, f, h, input logic [20:0] c, input logic [31:0] rs, rt,
                     input logic [4:0] rta, rd, input logic [20:0] ec, input logic [31:0] ers, ert,
                     input logic [4:0] erta, erd, input logic ev, emr, es, eh);
    vec_t v;
    v.rst = r; v.en = e; v.stall = s; v.flush = f; v.halt = h;
    v.ctrl = c; v.rs = rs; v.rt = rt; v.rta = rta; v.rd = rd;
    v.e_ctrl = ec; v.e_rs = ers; v.e_rt = ert; v.e_rta = erta; v.e_rd = erd;
    v.e_valid = ev; v.e_mr = emr; v.e_seen = es; v.e_halted = eh;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    ctrl = '0; pc4 = '0; rs_d = '0; rt_d = '0; imm = '0;
    rs_a = '0; rt_a = '0; rd_a = '0; sa = '0;
    model_bubble(); m_seen = 1'b0; m_drain = 0;

    //  rst en st fl ht  ctrl  rs rt rta rd | e_ctrl e_rs e_rt e_rta e_rd v mr seen halted
    add(1, 1, 0, 0, 0, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, ADDU, 5, 7, 0, 3,  ADDU, 5, 7, 0,  3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 1, 0, 0, ADDU, 9, 7, 0, 3, ADDU, 5, 7, 0, 3, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, ADDU, 9, 7, 0, 3,  ADDU, 9, 7, 0,  3, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, LOAD, 9, 7, 12, 3, 0,    0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, LOAD, 9, 7, 12, 3, LOAD, 9, 7, 12, 3, 1, 1, 0, 0);
    add(0, 1, 1, 0, 1, ADDU, 5, 7, 0, 3,  LOAD, 9, 7, 12, 3, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, LOAD, 5, 7, 4, 3,  0,    0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, LOAD, 5, 7, 4, 3,  0,    0, 0, 0,  0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, LOAD, 5, 7, 4, 3,  0,    0, 0, 0,  0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, ADDU, 5, 7, 0, 3,  0,    0, 0, 0,  0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 0, ADDU, 5, 7, 0, 3, ADDU, 5, 7, 0, 3, 1, 0, 0, 0);

    foreach (vq[i]) begin
      rst = vq[i].rst; en = vq[i].en; stall = vq[i].stall; flush = vq[i].flush; halt = vq[i].halt;
      ctrl = vq[i].ctrl; rs_d = vq[i].rs; rt_d = vq[i].rt; rt_a = vq[i].rta; rd_a = vq[i].rd;
      tick();
      check($sformatf("vec%0d_ctrl", i), 64'(o_ctrl), 64'(vq[i].e_ctrl));
      check($sformatf("vec%0d_rs_data", i), 64'(o_rs_d), 64'(vq[i].e_rs));
      check($sformatf("vec%0d_rt_data", i), 64'(o_rt_d), 64'(vq[i].e_rt));
      check($sformatf("vec%0d_rt_addr", i), 64'(o_rt_a), 64'(vq[i].e_rta));
      check($sformatf("vec%0d_rd_addr", i), 64'(o_rd_a), 64'(vq[i].e_rd));
      check($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vq[i].e_valid));
      check($sformatf("vec%0d_mem_read", i), 64'(o_mem_read), 64'(vq[i].e_mr));
      check($sformatf("vec%0d_halt_seen", i), 64'(o_halt_seen), 64'(vq[i].e_seen));
      check($sformatf("vec%0d_halted", i), 64'(o_halted), 64'(vq[i].e_halted));
    end

    // Freeze the step gate for 5 cycles after the first drain edge: o_halted arrives 5 edges late
    rst = 1'b1; tick();
    rst = 1'b0; halt = 1'b1; tick();
    halt = 1'b0;
    begin
      int edges;
      edges = 0;
      while (!o_halted && edges < 20) begin
        en = (edges >= 1 && edges < 6) ? 1'b0 : 1'b1;
        tick();
        edges++;
      end
      check("freeze_drain_edges", 64'(edges), 64'(DRAIN + 5));
    end
    en = 1'b1;

    rst = 1'b1; tick();
    check_model();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst   = ($urandom_range(0, 59) == 0);
      en    = ($urandom_range(0, 99) < 85);
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 15);
      halt  = ($urandom_range(0, 99) < 4);
      ctrl  = 21'($urandom);
      pc4   = $urandom; rs_d = $urandom; rt_d = $urandom; imm = $urandom;
      rs_a  = 5'($urandom); rt_a = 5'($urandom); rd_a = 5'($urandom); sa = 5'($urandom);
      tick();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
